// File: rtl/cp0_timer_int_pkg.sv
// Shared CP0 definitions for the Count/Compare timer and the interrupt-source bus.
package cp0_timer_int_pkg;

  localparam logic [4:0]  CP0_COUNT         = 5'd9;
  localparam logic [4:0]  CP0_COMPARE       = 5'd11;
  localparam int unsigned CP0_TIMER_INT_BIT = 5;
  localparam int unsigned TIMER_INT_W       = 6;
  localparam int unsigned CP0_INT_BUS       = TIMER_INT_W;
  localparam int unsigned EXT_INT_W         = 5;
  localparam int unsigned CP0_DATA_W        = 32;

  // One MTC0 write as seen by this block, after wr_block_i qualification.
  typedef struct packed {
    logic                  en;
    logic [4:0]            addr;
    logic [CP0_DATA_W-1:0] data;
  } cp0_wr_t;

endpackage

// File: rtl/cp0_int_sync.sv
// N-bit multi-stage synchroniser for asynchronous level interrupt lines.
// All stages clear on the synchronous reset.
module cp0_int_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d    = '0;
    sync_d[0] = async_i;
    for (int i = 1; i < int'(STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_timer_int.sv
// CP0 Count/Compare timer plus external-interrupt synchronisation, driving the
// registered interrupt-pending bus and the Count/Compare MFC0 readback.
module cp0_timer_int
  import cp0_timer_int_pkg::*;
#(
  parameter int unsigned COUNT_DIV   = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst,
  input  logic                   we,
  input  logic [4:0]             waddr,
  input  logic [CP0_DATA_W-1:0]  wdata,
  input  logic                   wr_block_i,
  input  logic                   re,
  input  logic [4:0]             raddr,
  input  logic [EXT_INT_W-1:0]   ext_int_i,
  output logic [CP0_INT_BUS-1:0] int_o,
  output logic [CP0_DATA_W-1:0]  data_o
);

  // Wide enough for a prescaler terminal value of up to 15.
  localparam int unsigned PRE_W = 4;

  cp0_wr_t                wr;
  logic                   wr_count;
  logic                   wr_compare;
  logic                   pre_tick;
  logic                   match;
  logic [CP0_DATA_W-1:0]  count_inc;

  logic [CP0_DATA_W-1:0]  count_q,      count_d;
  logic [CP0_DATA_W-1:0]  compare_q,    compare_d;
  logic [PRE_W-1:0]       prescaler_q,  prescaler_d;
  logic                   timer_pend_q, timer_pend_d;
  logic [CP0_INT_BUS-1:0] int_q,        int_d;
  logic [EXT_INT_W-1:0]   ext_sync;

  cp0_int_sync #(
    .WIDTH  (EXT_INT_W),
    .STAGES (SYNC_STAGES)
  ) u_ext_sync (
    .clk     (cpu_clk_50M),
    .rst     (cpu_rst),
    .async_i (ext_int_i),
    .sync_o  (ext_sync)
  );

  // Timer next state: a Count write overrides the increment and cannot match;
  // a Compare write clears the pending bit even against a same-cycle match.
  always_comb begin
    wr.en      = we & ~wr_block_i;
    wr.addr    = waddr;
    wr.data    = wdata;
    wr_count   = wr.en && (wr.addr == CP0_COUNT);
    wr_compare = wr.en && (wr.addr == CP0_COMPARE);
    pre_tick   = (prescaler_q == PRE_W'(COUNT_DIV - 1));
    count_inc  = count_q + 32'd1;
    match      = pre_tick && !wr_count && (count_inc == compare_q);

    count_d      = count_q;
    compare_d    = compare_q;
    prescaler_d  = prescaler_q + PRE_W'(1);
    timer_pend_d = timer_pend_q | match;

    if (pre_tick) begin
      count_d     = count_inc;
      prescaler_d = '0;
    end
    if (wr_count) begin
      count_d     = wr.data;
      prescaler_d = '0;
    end
    if (wr_compare) begin
      compare_d    = wr.data;
      timer_pend_d = 1'b0;
    end

    int_d                    = '0;
    int_d[EXT_INT_W-1:0]     = ext_sync;
    int_d[CP0_TIMER_INT_BIT] = timer_pend_q;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      count_q      <= '0;
      compare_q    <= '0;
      prescaler_q  <= '0;
      timer_pend_q <= 1'b0;
      int_q        <= '0;
    end else begin
      count_q      <= count_d;
      compare_q    <= compare_d;
      prescaler_q  <= prescaler_d;
      timer_pend_q <= timer_pend_d;
      int_q        <= int_d;
    end
  end

  assign int_o = int_q;

  // Readback shows the pre-write register value; no write bypass.
  always_comb begin
    data_o = '0;
    if (!cpu_rst && re) begin
      case (raddr)
        CP0_COUNT:   data_o = count_q;
        CP0_COMPARE: data_o = compare_q;
        default:     data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_timer_int.sv
// Self-checking bench for cp0_timer_int: directed test-plan scenarios followed
// by random traffic, all compared against an arithmetic reference model.
module tb_cp0_timer_int;

  localparam int unsigned DIV = 2;
  localparam int          SYN = 2;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        blk;
  logic        re;
  logic [4:0]  raddr;
  logic [4:0]  ext;
  logic [5:0]  int_o;
  logic [31:0] data_o;

  int n_total = 0;
  int n_pass  = 0;

  cp0_timer_int #(
    .COUNT_DIV   (DIV),
    .SYNC_STAGES (SYN)
  ) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .wr_block_i  (blk),
    .re          (re),
    .raddr       (raddr),
    .ext_int_i   (ext),
    .int_o       (int_o),
    .data_o      (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count = base + (edges since anchor)/DIV.
  logic [31:0] m_base;
  logic [31:0] m_cmp;
  int unsigned m_k;
  bit          m_pend;
  logic [5:0]  m_int;
  int          edge_n;
  int          rst_edge;
  logic [4:0]  ext_at [8192];

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_k / DIV);
  endfunction

  function automatic logic [31:0] exp_data();
    if (rst || !re) return 32'd0;
    if (raddr == 5'd9)  return m_count();
    if (raddr == 5'd11) return m_cmp;
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_base = '0; m_cmp = '0; m_k = 0; m_pend = 1'b0; m_int = '0;
  endtask

  task automatic model_update();
    logic [31:0] old_c;
    logic [31:0] new_c;
    bit          wrc;
    bit          wrm;
    bit          match;
    edge_n++;
    ext_at[edge_n] = ext;
    if (rst) begin
      model_reset();
      rst_edge = edge_n;
    end else begin
      old_c = m_count();
      wrc   = we && !blk && (waddr == 5'd9);
      wrm   = we && !blk && (waddr == 5'd11);
      m_int[5]   = m_pend;
      m_int[4:0] = (edge_n - SYN > rst_edge) ? ext_at[edge_n - SYN] : 5'd0;
      if (wrc) begin
        m_base = wdata;
        m_k    = 0;
      end else begin
        m_k++;
      end
      new_c = m_count();
      match = !wrc && (new_c != old_c) && (new_c == m_cmp);
      if (wrm) begin
        m_cmp  = wdata;
        m_pend = 1'b0;
      end else if (match) begin
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic tick();
    #1;
    chk("int_o", 32'(int_o), 32'(m_int));
    chk("data_o", data_o, exp_data());
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic read_cnt(input string name, input logic [31:0] exp);
    re = 1'b1; raddr = 5'd9;
    #1;
    chk(name, data_o, exp);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; blk = 1'b0;
    re = 1'b0; raddr = '0; ext = '0;
    edge_n = 0; rst_edge = 0;
    model_reset();
    @(negedge clk);

    // Reset release, free-running count, no spurious interrupt.
    tick(); tick();
    rst = 1'b0;
    repeat (2) tick();
    read_cnt("count_after_2", 32'd1);
    repeat (8) tick();
    read_cnt("count_after_10", 32'd5);
    repeat (30) tick();
    #1 chk("no_int_40", 32'(int_o), 32'd0);

    // Compare=5 written right after reset.
    rst = 1'b1; tick(); rst = 1'b0;
    we = 1'b1; waddr = 5'd11; wdata = 32'd5; tick(); we = 1'b0;
    repeat (9) tick();
    read_cnt("count_hits_5", 32'd5);
    chk("int5_not_yet", 32'(int_o[5]), 32'd0);
    tick();
    chk("int5_set", 32'(int_o[5]), 32'd1);
    tick();
    read_cnt("count_runs_6", 32'd6);

    // Compare write clears the pending timer interrupt.
    we = 1'b1; waddr = 5'd11; wdata = 32'h20; tick(); we = 1'b0;
    #1 chk("int5_still_1", 32'(int_o[5]), 32'd1);
    tick();
    chk("int5_cleared", 32'(int_o[5]), 32'd0);
    read_cnt("count_unaffected", 32'd7);

    // Count wrap onto Compare=0.
    we = 1'b1; waddr = 5'd11; wdata = 32'd0; tick();
    waddr = 5'd9; wdata = 32'hFFFF_FFFF; tick(); we = 1'b0;
    read_cnt("count_written", 32'hFFFF_FFFF);
    tick(); tick();
    read_cnt("count_wrapped", 32'd0);
    chk("wrap_int5_not_yet", 32'(int_o[5]), 32'd0);
    tick();
    chk("wrap_int5_set", 32'(int_o[5]), 32'd1);

    // Blocked Count write is dropped.
    we = 1'b1; blk = 1'b1; waddr = 5'd9; wdata = 32'h100; tick();
    we = 1'b0; blk = 1'b0;
    tick();
    read_cnt("blocked_write", 32'd1);
    tick(); tick();
    read_cnt("blocked_write_2", 32'd2);

    // External interrupt pulse on bit 2.
    re = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      ext = (i <= 4) ? 5'd4 : 5'd0;
      tick();
      #1 chk("ext_pulse", 32'(int_o[4:0]), (i >= 3 && i <= 6) ? 32'd4 : 32'd0);
    end

    // Reset coinciding with a Count/Compare match.
    rst = 1'b1; tick(); rst = 1'b0;
    we = 1'b1; waddr = 5'd11; wdata = 32'd3; tick(); we = 1'b0;
    repeat (4) tick();
    rst = 1'b1; re = 1'b1; raddr = 5'd9;
    #1 chk("data_in_rst", data_o, 32'd0);
    tick();
    rst = 1'b0;
    #1 chk("rst_match_int", 32'(int_o), 32'd0);
    read_cnt("rst_match_count", 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      we  = ($urandom_range(0, 5) == 0);
      blk = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       waddr = 5'd9;
        1, 2:    waddr = 5'd11;
        default: waddr = 5'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       wdata = $urandom;
        1:       wdata = m_count() + 32'($urandom_range(0, 6));
        default: wdata = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
      re = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       raddr = 5'd9;
        1:       raddr = 5'd11;
        default: raddr = 5'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) ext = 5'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cp0_timer_int.md
Name: cp0_timer_int

Overview:
- Interrupt-source stage directly upstream of the CP0 register file.
- Holds the CP0 Count (reg 9) and Compare (reg 11) registers and raises a level timer interrupt on Count/Compare match.
- Synchronises five asynchronous external hardware interrupt lines.
- Drives the 6-bit int_o bus, which the CP0 register file latches into Cause[15:10] every cycle. Also returns Count/Compare readback for MFC0.

Parameters:
- COUNT_DIV, 2: clock cycles per Count increment; legal range 1..16.
- SYNC_STAGES, 2: flop stages in each external-interrupt synchroniser; legal range 2..3.

Ports:
- cpu_clk_50M  in  1  system clock; every flop is rising-edge on it.
- cpu_rst  in  1  synchronous, active-high reset.
- we  in  1  CP0 write enable (MTC0), shared with the CP0 register file.
- waddr  in  5  CP0 write register number.
- wdata  in  32  CP0 write data.
- wr_block_i  in  1  high when an exception or ERET is in flight this cycle; suppresses writes.
- re  in  1  CP0 read enable (MFC0).
- raddr  in  5  CP0 read register number.
- ext_int_i  in  5  asynchronous level hardware interrupts, active-high.
- int_o  out  6  registered interrupt pending bus to CP0 int_i: [4:0] external, [5] timer.
- data_o  out  32  combinational Count/Compare readback.

Behaviour:
- Reset (cpu_rst=1 at a rising edge) clears: count=0, compare=0, prescaler=0, timer_pend=0, all synchroniser flops=0, int_o=0.
- data_o is 0 while cpu_rst=1.
- Reset has priority over every other event, including a write or match in the same cycle.
- A write is effective when we=1 and wr_block_i=0. A write with wr_block_i=1 is dropped entirely.
- Prescaler runs 0..COUNT_DIV-1. When it equals COUNT_DIV-1: count <= count+1 (32-bit wrap 0xFFFFFFFF -> 0) and prescaler <= 0. Otherwise prescaler <= prescaler+1.
- Effective write with waddr=CP0_COUNT: count <= wdata and prescaler <= 0. This overrides any increment in the same cycle.
- Effective write with waddr=CP0_COMPARE: compare <= wdata and timer_pend <= 0.
- Match is edge-based, not static equality. timer_pend <= 1 on the edge where an increment moves count to a value equal to the current (pre-write) compare.
  - Consequence: no interrupt immediately after reset even though count=compare=0.
  - Writing Count equal to Compare does not raise a match.
- Simultaneous match and Compare write in the same cycle: the clear wins, so timer_pend=0.
- timer_pend is sticky until a Compare write or reset. Count keeps running afterwards.
- External interrupts:
  - Each bit passes through SYNC_STAGES flops, then int_o[i] is registered from the last stage.
  - Latency from an ext_int_i edge to int_o[i] is SYNC_STAGES+1 edges.
  - Level-sensitive: no latching; a deasserted line clears int_o[i] with the same latency.
- Timer bit: int_o[5] is registered from timer_pend, so it appears 1 cycle after timer_pend sets.
- Readback (data_o):
  - re=0 -> 0.
  - raddr=CP0_COUNT -> count.
  - raddr=CP0_COMPARE -> compare.
  - Any other raddr -> 0.
  - A read in the same cycle as a write to the same register returns the pre-write value; there is no bypass.
- The CP0 read mux selects this block's data_o only for registers 9 and 11.

Decomposition:
- Shared defines header gains CP0_COUNT=5'd9, CP0_COMPARE=5'd11, CP0_TIMER_INT_BIT=5 and TIMER_INT_W=6.
- The existing CP0_INT_BUS width is reused for int_o.
- One sub-module: cp0_int_sync, a parameterised N-bit, SYNC_STAGES-deep reset-clearing synchroniser, instantiated once at width 5.
- Count/Compare/prescaler logic stays in the top module.

Test Plan:
- Reset, then release; Compare stays 0 and COUNT_DIV=2.
  - After release: count=1 after 2 cycles, 5 after 10 cycles.
  - int_o stays 0 for 40 cycles.
- Write Compare=5 in the first cycle after reset.
  - Edge where count becomes 5: timer_pend=1; int_o[5]=1 one cycle later.
  - Count continues: reads 6 two cycles after reaching 5.
- With timer_pend=1, write Compare=0x20 -> int_o[5]=0 one cycle after the write; count is unaffected.
- Write Count=0xFFFFFFFF with Compare=0 -> count wraps to 0 two cycles later, raising timer_pend; int_o[5]=1 the cycle after.
- Write Count=0x100 with wr_block_i=1 -> count ignores it and keeps incrementing; re=1, raddr=9 shows the old sequence.
- Pulse ext_int_i[2]=1 for 4 cycles -> int_o[2]=1 for exactly 4 cycles starting 3 edges later; other bits stay 0.
- Assert cpu_rst in the same cycle as a match -> int_o=0 and count=0 next cycle.
